// File: rtl/alu_seq.sv
// Registered ALU with an iterative shift-add multiplier.
// One op in flight; valid/ready handshake on both sides.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] acc_nxt;
    logic [SHW-1:0]   shamt;

    assign shamt   = op2[SHW-1:0];
    assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        alu = '0;
        case (control)
            OP_ADD:  alu = op1 + op2;
            OP_SUB:  alu = op1 - op2;
            OP_AND:  alu = op1 & op2;
            OP_OR:   alu = op1 | op2;
            OP_XOR:  alu = op1 ^ op2;
            OP_SLT:  alu = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: alu = {{(WIDTH-1){1'b0}}, op1 < op2};
            OP_SLL:  alu = op1 << shamt;
            OP_SRL:  alu = op1 >> shamt;
            OP_SRA:  alu = WIDTH'($signed(op1) >>> shamt);
            default: alu = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (control == OP_MUL) begin
                        mcand_d  = op1;
                        mplier_d = op2;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d = alu;
                        zero_d   = (alu == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Fixed WIDTH iterations; the last one writes straight through.
                if (cnt_q == LAST) begin
                    result_d = acc_nxt;
                    zero_d   = (acc_nxt == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [3:0]  control = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  op1_8 = '0;
    logic [7:0]  op2_8 = '0;
    logic [3:0]  control8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [7:0]  result8;
    logic        zero8;
    logic        busy8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .control(control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .op1(op1_8), .op2(op2_8), .control(control8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .zero(zero8), .busy(busy8)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [31:0] res;
        logic        z;
        int          lat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat = edges after the accept edge until out_valid is seen
    task automatic run(input vec_t v);
        int lat;
        check({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
        op1 = v.a; op2 = v.b; control = v.ctl;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({v.name, ".lat"}, 32'(lat), 32'(v.lat));
        check({v.name, ".result"}, result, v.res);
        check({v.name, ".zero"}, 32'(zero), 32'(v.z));
        tick();
        check({v.name, ".idle"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run8(input string nm, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] c,
                        input logic [7:0] er, input logic ez,
                        input int elat);
        int lat;
        op1_8 = a; op2_8 = b; control8 = c; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin
            tick();
            lat++;
        end
        check({nm, ".lat"}, 32'(lat), 32'(elat));
        check({nm, ".result"}, 32'(result8), 32'(er));
        check({nm, ".zero"}, 32'(zero8), 32'(ez));
        tick();
        check({nm, ".idle"}, 32'(in_ready8), 32'd1);
    endtask

    vec_t tbl[$];

    initial begin
        int lat;
        int bc;
        tbl.push_back('{"add_wrap", 32'hFFFF_FFFF, 32'h1, 4'b0000, 32'h0, 1'b1, 0});
        tbl.push_back('{"sub", 32'd5, 32'd7, 4'b0001, 32'hFFFF_FFFE, 1'b0, 0});
        tbl.push_back('{"and", 32'hF0F0_1234, 32'h0FF0_FF00, 4'b0010, 32'h00F0_1200, 1'b0, 0});
        tbl.push_back('{"or", 32'hF000_0001, 32'h0000_0F00, 4'b0011, 32'hF000_0F01, 1'b0, 0});
        tbl.push_back('{"xor", 32'hAAAA_5555, 32'hAAAA_5555, 4'b0100, 32'h0, 1'b1, 0});
        tbl.push_back('{"slt", 32'hFFFF_FFFF, 32'h1, 4'b0101, 32'h1, 1'b0, 0});
        tbl.push_back('{"sltu", 32'hFFFF_FFFF, 32'h1, 4'b0110, 32'h0, 1'b1, 0});
        tbl.push_back('{"sll", 32'h0000_0001, 32'h21, 4'b0111, 32'h2, 1'b0, 0});
        tbl.push_back('{"srl", 32'h8000_0000, 32'h1F, 4'b1000, 32'h1, 1'b0, 0});
        tbl.push_back('{"sra", 32'h8000_0000, 32'h24, 4'b1001, 32'hF800_0000, 1'b0, 0});
        tbl.push_back('{"mul_zero", 32'h1234_5678, 32'h0, 4'b1010, 32'h0, 1'b1, 32});
        tbl.push_back('{"mul_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1010, 32'h1, 1'b0, 32});
        tbl.push_back('{"unused", 32'h1234, 32'h5678, 4'b1111, 32'h0, 1'b1, 0});

        // in_valid held during reset must not be accepted
        op1 = 32'h5; op2 = 32'h6; control = 4'b0000; in_valid = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.zero", 32'(zero), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        tick();
        check("rst.no_accept", 32'(out_valid), 32'd0);

        foreach (tbl[i]) run(tbl[i]);

        // MUL with op1 disturbed mid-operation
        op1 = 32'h0001_0003; op2 = 32'h5; control = 4'b1010;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        bc = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bc++;
            if (lat == 5) op1 = 32'hDEAD_BEEF;
            if (lat == 7) op2 = 32'hFFFF_FFFF;
            tick();
            lat++;
        end
        check("mul.lat", 32'(lat), 32'd32);
        check("mul.busy_cycles", 32'(bc), 32'd32);
        check("mul.result", result, 32'h0005_000F);
        check("mul.zero", 32'(zero), 32'd0);
        tick();
        check("mul.idle", 32'(in_ready), 32'd1);

        // backpressure: result held, no new accept
        op1 = 32'd3; op2 = 32'd4; control = 4'b0000;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        op1 = 32'd100;
        for (int i = 0; i < 5; i++) begin
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.result", result, 32'd7);
            check("bp.in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp.release", 32'(in_ready), 32'd1);
        check("bp.out_valid_low", 32'(out_valid), 32'd0);

        // reset during MUL
        op1 = 32'h0001_0003; op2 = 32'h5; control = 4'b1010;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("rmul.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rmul.in_ready", 32'(in_ready), 32'd1);
        check("rmul.out_valid", 32'(out_valid), 32'd0);
        check("rmul.result", result, 32'd0);
        check("rmul.zero", 32'(zero), 32'd0);
        check("rmul.busy", 32'(busy), 32'd0);
        begin
            vec_t v;
            v = '{"post_rst_add", 32'd1, 32'd1, 4'b0000, 32'd2, 1'b0, 0};
            run(v);
        end

        run8("w8.mul", 8'h0F, 8'h11, 4'b1010, 8'hFF, 1'b0, 8);
        run8("w8.add", 8'hFF, 8'h01, 4'b0000, 8'h00, 1'b1, 0);
        run8("w8.sra", 8'h80, 8'h0B, 4'b1001, 8'hF0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
